mc_main_controller: RTL and testbench
=====================================

Name: mc_main_controller

Overview:
- Multicycle MIPS main control unit; sits directly upstream of the ALU controller and drives its 2-bit alu_ctrl class input.
- Decodes the instruction opcode through a Moore FSM with mem_ready stall handshakes.
- Produces per-state datapath enables, mux selects and the ALU class code.
- Keeps a retired-fetch counter for debug and performance readout.

Parameters:
CNT_W, 16, width of the fetched-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (branch)
i_or_d  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load IR from memory data
mem_to_reg  out  1  1=MDR to register file, 0=ALUOut
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_ctrl  out  2  ALU class to ALU controller: 00 MTYPE(add), 01 BTYPE(sub), 10 RTYPE(func), 11 JTYPE(off)
fetch_count  out  CNT_W  completed fetches since reset

Behaviour:
- Reset: state=FETCH, fetch_count=0. Outputs are decoded from state, so during reset they carry FETCH values with mem_ready-gated signals at 0.
- Undriven outputs are 0 in every state; alu_ctrl defaults to 00.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_src=00, alu_ctrl=00.
  - ir_write and pc_write = mem_ready.
  - Stay in FETCH while !mem_ready; on mem_ready go to DECODE and increment fetch_count (wraps to 0).
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=00. Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000000 (R-type) -> R_EXEC
  - 001000 (ADDI) -> I_EXEC
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - any other opcode -> FETCH (treated as NOP; no writes issued)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=00. Go to MEM_READ if LW, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Hold while !mem_ready; on mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold while !mem_ready; on mem_ready -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_ctrl=00 -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=01, pc_write_cond=1, pc_src=01 -> FETCH.
- JUMP: pc_write=1, pc_src=10, alu_ctrl=11 -> FETCH.
- Latency with mem_ready tied high:
  - LW 5 cycles; SW, R-type and ADDI 4 cycles; BEQ and J 3 cycles.
  - Each mem_ready-low cycle adds one cycle.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states have no effect.
- rst asserted in any state, including mid-stall: immediate return to FETCH and fetch_count=0; no pending write completes after reset.
- Unreachable state encodings recover to FETCH on the next clock.

Decomposition:
- Shared constants header, the same one holding the ALU codes:
  - opcode values OP_RTYPE/OP_LW/OP_SW/OP_ADDI/OP_BEQ/OP_J
  - ALU_CTRL_MTYPE/BTYPE/RTYPE/JTYPE encodings
  - state encodings S_FETCH..S_JUMP (4-bit)
  - alu_src_b and pc_src select constants
- Single module. No sub-module: the counter is one always block, and the next-state and output decode fit one process each.

Test Plan:
- rst=1 mid-MEM_READ stall, mem_ready=0 -> same cycle: state FETCH, fetch_count=0, reg_write=0, mem_write=0.
- mem_ready=1, opcode=000000 -> states FETCH,DECODE,R_EXEC,R_WB. alu_ctrl sequence 00,00,10,00; reg_write=1 and reg_dst=1 only in cycle 4; fetch_count 0->1.
- opcode=100011, mem_ready low for 2 cycles in FETCH and 3 in MEM_READ -> 10 cycles total. ir_write/pc_write high only in the mem_ready cycle; mem_to_reg=1 with reg_write in the final cycle.
- opcode=000100 -> BRANCH cycle has alu_ctrl=01, pc_write_cond=1, pc_src=01, pc_write=0. Next fetch follows after 3 cycles.
- opcode=000010, then opcode=111111 -> J: JUMP with pc_write=1, pc_src=10, alu_ctrl=11. Illegal opcode: DECODE returns to FETCH, zero writes issued.
- CNT_W=4, run 17 fetches -> fetch_count reads 15 then wraps to 0 then 1.

Source files
------------

// File: rtl/mc_main_controller_pkg.sv
// Shared constants for the multicycle MIPS control path:
// opcodes, ALU class codes, FSM states and mux selects.
package mc_main_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_CTRL_MTYPE = 2'b00;
  localparam logic [1:0] ALU_CTRL_BTYPE = 2'b01;
  localparam logic [1:0] ALU_CTRL_RTYPE = 2'b10;
  localparam logic [1:0] ALU_CTRL_JTYPE = 2'b11;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

endpackage

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM (Moore) with mem_ready
// stalls and a wrapping retired-fetch counter.
module mc_main_controller
  import mc_main_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_ctrl,
  output logic [CNT_W-1:0] fetch_count
);

  state_t state;
  state_t state_next;
  logic   ready;

  // Memory handshakes are ignored while reset is held.
  assign ready = mem_ready & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (state == S_FETCH && mem_ready) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    unique case (state)
      S_FETCH:
        state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_ADDI:      state_next = S_I_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_next = (opcode == OP_LW) ? S_MEM_READ
                                       : S_MEM_WRITE;
      S_MEM_READ:
        state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE:
        state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC: state_next = S_R_WB;
      S_I_EXEC: state_next = S_I_WB;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_src        = PC_SRC_ALU;
    alu_ctrl      = ALU_CTRL_MTYPE;
    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE: alu_src_b = SRC_B_IMM_SH;
      S_MEM_ADDR, S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_CTRL_RTYPE;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_CTRL_BTYPE;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        alu_ctrl = ALU_CTRL_JTYPE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed scoreboard bench for mc_main_controller:
// stimulus queues expected outputs, a monitor compares each cycle.
module tb_mc_main_controller;

  typedef enum int {
    FETCH, DECODE, MADDR, MREAD, MWB, MWRITE,
    REXEC, RWB, IEXEC, IWB, BRANCH, JUMP
  } st_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_ctrl;
    logic [3:0] fetch_count;
  } out_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  out_t       act;

  mc_main_controller #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (act.pc_write),
    .pc_write_cond(act.pc_write_cond),
    .i_or_d       (act.i_or_d),
    .mem_read     (act.mem_read),
    .mem_write    (act.mem_write),
    .ir_write     (act.ir_write),
    .mem_to_reg   (act.mem_to_reg),
    .reg_dst      (act.reg_dst),
    .reg_write    (act.reg_write),
    .alu_src_a    (act.alu_src_a),
    .alu_src_b    (act.alu_src_b),
    .pc_src       (act.pc_src),
    .alu_ctrl     (act.alu_ctrl),
    .fetch_count  (act.fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t       q_exp[$];
  string      q_name[$];
  int         checks = 0;
  int         passed = 0;
  logic [3:0] exp_cnt = 4'd0;

  function automatic out_t exp_out(st_e st, logic mr,
                                   logic r, logic [3:0] c);
    out_t o;
    o = '0;
    o.fetch_count = c;
    case (st)
      FETCH: begin
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = mr & ~r;
        o.pc_write  = mr & ~r;
      end
      DECODE: o.alu_src_b = 2'b11;
      MADDR, IEXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
      end
      MREAD: begin
        o.mem_read = 1'b1;
        o.i_or_d   = 1'b1;
      end
      MWB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
      end
      MWRITE: begin
        o.mem_write = 1'b1;
        o.i_or_d    = 1'b1;
      end
      REXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_ctrl  = 2'b10;
      end
      RWB: begin
        o.reg_write = 1'b1;
        o.reg_dst   = 1'b1;
      end
      IWB: o.reg_write = 1'b1;
      BRANCH: begin
        o.alu_src_a     = 1'b1;
        o.alu_ctrl      = 2'b01;
        o.pc_write_cond = 1'b1;
        o.pc_src        = 2'b01;
      end
      JUMP: begin
        o.pc_write = 1'b1;
        o.pc_src   = 2'b10;
        o.alu_ctrl = 2'b11;
      end
      default: ;
    endcase
    return o;
  endfunction

  // One clock of stimulus; st is the state the DUT should show.
  task automatic cyc(input logic r, input st_e st,
                     input logic mr, input logic [5:0] op,
                     input string nm);
    rst       = r;
    mem_ready = mr;
    opcode    = op;
    if (r) exp_cnt = 4'd0;
    q_exp.push_back(exp_out(st, mr, r, exp_cnt));
    q_name.push_back(nm);
    @(posedge clk);
    #1;
    if (!r && st == FETCH && mr) exp_cnt = exp_cnt + 4'd1;
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      out_t  e;
      string n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      checks++;
      if (act !== e)
        $display("FAIL %s: got %h expected %h t=%0t",
                 n, act, e, $time);
      else
        passed++;
    end
  end

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'b111111;
    @(posedge clk);
    #1;
    cyc(1, FETCH, 0, 6'h3f, "reset");
    cyc(1, FETCH, 1, 6'h3f, "reset_mr_gated");

    cyc(0, FETCH,  1, 6'h2b, "r_fetch");
    cyc(0, DECODE, 1, 6'h00, "r_decode");
    cyc(0, REXEC,  1, 6'h04, "r_exec");
    cyc(0, RWB,    1, 6'h02, "r_wb");

    cyc(0, FETCH,  0, 6'h23, "lw_fetch_stall0");
    cyc(0, FETCH,  0, 6'h23, "lw_fetch_stall1");
    cyc(0, FETCH,  1, 6'h23, "lw_fetch");
    cyc(0, DECODE, 1, 6'h23, "lw_decode");
    cyc(0, MADDR,  1, 6'h23, "lw_addr");
    cyc(0, MREAD,  0, 6'h00, "lw_read_stall0");
    cyc(0, MREAD,  0, 6'h00, "lw_read_stall1");
    cyc(0, MREAD,  0, 6'h00, "lw_read_stall2");
    cyc(0, MREAD,  1, 6'h00, "lw_read");
    cyc(0, MWB,    1, 6'h00, "lw_wb");

    cyc(0, FETCH,  1, 6'h2b, "sw_fetch");
    cyc(0, DECODE, 1, 6'h2b, "sw_decode");
    cyc(0, MADDR,  1, 6'h2b, "sw_addr");
    cyc(0, MWRITE, 0, 6'h23, "sw_write_stall");
    cyc(0, MWRITE, 1, 6'h23, "sw_write");

    cyc(0, FETCH,  1, 6'h08, "addi_fetch");
    cyc(0, DECODE, 1, 6'h08, "addi_decode");
    cyc(0, IEXEC,  1, 6'h00, "addi_exec");
    cyc(0, IWB,    1, 6'h00, "addi_wb");

    cyc(0, FETCH,  1, 6'h04, "beq_fetch");
    cyc(0, DECODE, 1, 6'h04, "beq_decode");
    cyc(0, BRANCH, 1, 6'h04, "beq_branch");

    cyc(0, FETCH,  1, 6'h02, "j_fetch");
    cyc(0, DECODE, 1, 6'h02, "j_decode");
    cyc(0, JUMP,   1, 6'h02, "j_jump");

    cyc(0, FETCH,  1, 6'h3f, "ill_fetch");
    cyc(0, DECODE, 1, 6'h3f, "ill_decode");

    cyc(0, FETCH,  1, 6'h23, "rst_lw_fetch");
    cyc(0, DECODE, 1, 6'h23, "rst_lw_decode");
    cyc(0, MADDR,  1, 6'h23, "rst_lw_addr");
    cyc(0, MREAD,  0, 6'h23, "rst_lw_stall");
    cyc(1, FETCH,  0, 6'h23, "rst_mid_stall");
    cyc(0, FETCH,  0, 6'h23, "post_rst_fetch");

    for (int i = 0; i < 17; i++) begin
      cyc(0, FETCH,  1, 6'h3f, "wrap_fetch");
      cyc(0, DECODE, 1, 6'h3f, "wrap_decode");
    end
    cyc(0, FETCH, 0, 6'h00, "wrap_final");

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0",
               q_exp.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
